// File: rtl/interface_24in_256out.sv
// -----------------------------------------------------------------------------
// interface_24in_256out
//
// Packs a stream of 24-bit pixels into 256-bit words for the DDR3 write FIFO.
// Each output beat is {data[255:0], byte_valid[31:0]}. Stream byte k of a word
// (k = 0..31) lands in data[255-8k -: 8] and is flagged by byte_valid[31-k].
// This is the same byte order the 256-in/24-out read path consumes, so a frame
// written through this block reads back pixel-identical. 32 pixels fill exactly
// three words, and pixels may straddle a word boundary.
//
// Ports
//   clock          single clock for all logic
//   rst_n          synchronous, active-low reset
//   rx_data        pixel; rx_data[23:16] is the first byte in stream order
//   rx_data_valid  pixel valid
//   rx_ready_out   pixel accepted when rx_data_valid & rx_ready_out
//   flush_in       emit the partial word (end of line/frame); a pixel on the
//                  same cycle has priority, so the source must hold flush_in
//   tx_data        {data[255:0], byte_valid[31:0]}
//   tx_data_valid  output word valid
//   tx_req_in      downstream ready; transfer on tx_data_valid & tx_req_in
//   tx_last        word was produced by a flush
//   tx_word_cnt    words transferred since reset, wraps modulo 2^WCNT_W
// -----------------------------------------------------------------------------
module interface_24in_256out #(
   parameter int WCNT_W = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [23:0]       rx_data,
   input  logic              rx_data_valid,
   output logic              rx_ready_out,
   input  logic              flush_in,
   output logic [287:0]      tx_data,
   output logic              tx_data_valid,
   input  logic              tx_req_in,
   output logic              tx_last,
   output logic [WCNT_W-1:0] tx_word_cnt
);

   // Assembly state: bytes [0 .. asm_cnt-1] of asm_buf hold data, the rest are
   // kept at zero so a flushed partial word needs no extra masking.
   logic [255:0] asm_buf;
   logic [4:0]   asm_cnt;

   // Pixel bytes in stream order: pix_bytes[2] is byte 0 (rx_data[23:16]).
   logic [2:0][7:0] pix_bytes;

   logic [255:0] buf_fill;    // current word with the pixel merged in
   logic [255:0] buf_carry;   // bytes spilling into the next word
   logic [31:0]  flush_mask;  // byte_valid for a partial word

   logic out_free;
   logic pix_acc;
   logic flush_acc;
   logic word_load;
   logic flush_emit;
   logic load;
   logic xfer;

   assign pix_bytes = rx_data;

   // The output register can take a new word when it is empty or is being
   // drained this same cycle, which gives back-to-back full throughput.
   assign out_free     = ~tx_data_valid | tx_req_in;
   assign rx_ready_out = rst_n & out_free;

   assign pix_acc    = rx_data_valid & rx_ready_out;
   assign flush_acc  = flush_in & ~rx_data_valid & rx_ready_out;
   // A pixel at asm_cnt 29..31 reaches or crosses byte 31 and closes the word.
   assign word_load  = pix_acc & (asm_cnt >= 5'd29);
   // Flushing an empty buffer is accepted but produces nothing.
   assign flush_emit = flush_acc & (asm_cnt != 5'd0);
   assign load       = word_load | flush_emit;
   assign xfer       = tx_data_valid & tx_req_in;

   // Leading asm_cnt bits of byte_valid set, the rest clear.
   assign flush_mask = ~(32'hFFFF_FFFF >> asm_cnt);

   // Scatter the three pixel bytes: positions below 32 go into the current
   // word, positions 32 and up wrap into the start of the next word.
   always_comb begin
      int pos;
      // NOTE: every variable gets a value before any branch, so no path can
      // leave one unassigned and synthesis never infers a latch here.
      buf_fill  = asm_buf;
      buf_carry = '0;
      pos       = 0;
      for (int i = 0; i < 3; i++) begin
         pos = int'(asm_cnt) + i;
         if (pos < 32) begin
            buf_fill[255 - 8*pos -: 8] = pix_bytes[2 - i];
         end else begin
            buf_carry[255 - 8*(pos - 32) -: 8] = pix_bytes[2 - i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         // NOTE: asm_buf is cleared on reset, unlike a plain data store,
         // because unfilled bytes must read as zero in a flushed word.
         asm_buf       <= '0;
         asm_cnt       <= '0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         tx_last       <= 1'b0;
         tx_word_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register
         // samples the pre-edge values no matter the statement order.
         if (xfer) begin
            tx_word_cnt <= tx_word_cnt + WCNT_W'(1);
         end

         if (pix_acc) begin
            // 5-bit wrap of asm_cnt + 3 yields 0, 1 or 2 leftover bytes
            // exactly when the word completes.
            asm_cnt <= asm_cnt + 5'd3;
            asm_buf <= word_load ? buf_carry : buf_fill;
         end else if (flush_emit) begin
            asm_cnt <= '0;
            asm_buf <= '0;
         end

         if (load) begin
            tx_data       <= word_load ? {buf_fill, 32'hFFFF_FFFF}
                                       : {asm_buf, flush_mask};
            tx_data_valid <= 1'b1;
            tx_last       <= flush_emit;
         end else if (xfer) begin
            tx_data_valid <= 1'b0;
         end
      end
   end

endmodule
